// File: rtl/weight_load_ctrl.sv
// Weight buffer load sequencer: fetches one burst per filter set, releases it to the
// PE array, frees the buffer and loops until all sets of the layer are done.
module weight_load_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BEAT_BYTES = 8,
  parameter int unsigned M1_BEATS   = 88,
  parameter int unsigned M2_BEATS   = 44,
  parameter int unsigned M3_BEATS   = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode_in,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_sets,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [6:0]        mem_rd_len,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  output logic              wb_data_valid,
  input  logic              wb_ready,
  output logic              wb_output_filter,
  output logic              wb_free,
  input  logic              pe_round_done,
  output logic              busy,
  output logic              done,
  output logic              err_stray
);

  localparam int unsigned LEN_W = 7;
  localparam int unsigned SET_W = 8;

  typedef enum logic [2:0] {
    IDLE, REQ, FILL, WAIT_RDY, OUTPUT, FREE, DONE
  } state_t;

  state_t state_q, next_state;

  logic [LEN_W-1:0]  beats_q;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [SET_W-1:0]  sets_left_q;
  logic              aborting_q;
  logic              req_q, free_q, filter_q, done_q, stray_q, busy_q;
  logic              abort_act;
  logic              last_beat;

  function automatic logic [LEN_W-1:0] beats_of(input logic [1:0] m);
    case (m)
      2'd1:    return LEN_W'(M2_BEATS);
      2'd2:    return LEN_W'(M3_BEATS);
      default: return LEN_W'(M1_BEATS);
    endcase
  endfunction

  assign abort_act = abort && (state_q != IDLE);
  assign last_beat = mem_rd_valid && (beat_cnt_q == beats_q - LEN_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= next_state;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:     if (start) next_state = (num_sets == SET_W'(0)) ? DONE : REQ;
      REQ:      if (mem_rd_gnt) next_state = FILL;
      FILL:     if (last_beat) next_state = WAIT_RDY;
      WAIT_RDY: if (wb_ready) next_state = OUTPUT;
      OUTPUT:   if (pe_round_done) next_state = FREE;
      FREE: begin
        if (aborting_q)                      next_state = IDLE;
        else if (sets_left_q != SET_W'(1))   next_state = REQ;
        else                                 next_state = DONE;
      end
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (abort_act) next_state = (state_q == FREE) ? IDLE : FREE;
  end

  // Layer context, beat counter and burst address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q     <= '0;
      beat_cnt_q  <= '0;
      cur_addr_q  <= '0;
      sets_left_q <= '0;
      aborting_q  <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        aborting_q <= 1'b0;
        if (start) begin
          beats_q     <= beats_of(mode_in);
          cur_addr_q  <= base_addr;
          sets_left_q <= num_sets;
        end
      end else if (abort_act) begin
        aborting_q <= 1'b1;
      end else begin
        if (state_q == REQ && mem_rd_gnt)  beat_cnt_q <= '0;
        if (state_q == FILL && mem_rd_valid) beat_cnt_q <= beat_cnt_q + LEN_W'(1);
        if (state_q == FREE && !aborting_q) begin
          sets_left_q <= sets_left_q - SET_W'(1);
          cur_addr_q  <= cur_addr_q + ADDR_W'(ADDR_W'(beats_q) * ADDR_W'(BEAT_BYTES));
        end
      end
    end
  end

  // Registered outputs aligned with the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= 1'b0;
      free_q   <= 1'b0;
      filter_q <= 1'b0;
      done_q   <= 1'b0;
      stray_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      req_q    <= (next_state == REQ);
      free_q   <= (next_state == FREE);
      filter_q <= (state_q == OUTPUT) && (next_state == OUTPUT);
      done_q   <= (state_q == DONE) && (next_state == IDLE);
      stray_q  <= mem_rd_valid && (state_q != FILL);
      busy_q   <= (next_state != IDLE);
    end
  end

  assign mem_rd_req       = req_q;
  assign mem_rd_addr      = cur_addr_q;
  assign mem_rd_len       = beats_q;
  assign wb_data_valid    = (state_q == FILL) && mem_rd_valid && !abort;
  assign wb_output_filter = filter_q;
  assign wb_free          = free_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err_stray        = stray_q;

endmodule
